// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: bus widths, tile map geometry, colour byte layout
// and the owner ids that travel down the arbiter pipeline.
package vga_pkg;

    localparam int VRAM_AW     = 11;
    localparam int VRAM_DW     = 8;

    localparam int MAP_COLS    = 40;
    localparam int MAP_ROWS    = 30;
    localparam int MAP_WORDS   = MAP_COLS * MAP_ROWS;

    // 2-2-2 colour byte: bits [7:6] unused
    localparam int COL_FIELD_W = 2;
    localparam int COL_R_LSB   = 4;
    localparam int COL_G_LSB   = 2;
    localparam int COL_B_LSB   = 0;

    typedef enum logic [1:0] {
        PORT_VGA = 2'd0,
        PORT_A   = 2'd1,
        PORT_B   = 2'd2
    } port_id_e;

    typedef struct packed {
        logic     valid;
        logic     we;
        port_id_e id;
    } slot_t;

    function automatic logic slot_owned_by(input slot_t s, input port_id_e p);
        return s.valid && (s.id == p);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Ports that are busy are skipped; after any grant
// the pointer moves to the port that did not win.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] busy,
    output logic [1:0] gnt
);

    logic       ptr;    // 0 favours port 0, 1 favours port 1
    logic [1:0] elig;

    always_comb begin
        elig = req & ~busy;
        gnt  = 2'b00;
        if (en) begin
            case (elig)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scan-out has absolute priority, game ports A/B
// share the leftover slots round-robin. Fixed 3-cycle request-to-completion latency.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // Handshake: a game port raises req with we/addr/wdata stable and holds them
    // until the one-cycle ack; ack always lands 3 cycles after the grant cycle.
    // The in-flight flag stays set through the ack cycle, so a req still high in
    // that cycle is not re-granted; a new request wins no earlier than ack+1.

    logic          a_inflight;
    logic          b_inflight;
    logic [1:0]    gnt;

    slot_t         sel;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    slot_t         s1;     // owner of the slot currently on ram_*
    slot_t         s2;     // owner of the slot whose data is on ram_rdata

    rr_arb2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .en   (!vga_req),
        .req  ({b_req, a_req}),
        .busy ({b_inflight, a_inflight}),
        .gnt  (gnt)
    );

    always_comb begin
        sel       = '{valid: 1'b0, we: 1'b0, id: PORT_VGA};
        sel_addr  = '0;
        sel_wdata = '0;
        if (vga_req) begin
            sel.valid = 1'b1;
            sel.id    = PORT_VGA;
            sel_addr  = vga_addr;
        end else if (gnt[0]) begin
            sel.valid = 1'b1;
            sel.we    = a_we;
            sel.id    = PORT_A;
            sel_addr  = a_addr;
            sel_wdata = a_we ? a_wdata : '0;
        end else if (gnt[1]) begin
            sel.valid = 1'b1;
            sel.we    = b_we;
            sel.id    = PORT_B;
            sel_addr  = b_addr;
            sel_wdata = b_we ? b_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            s1        <= '0;
            s2        <= '0;
        end else begin
            ram_en    <= sel.valid;
            ram_we    <= sel.valid & sel.we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            s1        <= sel;
            s2        <= s1;
        end
    end

    // Only the slot owner's rdata register moves; the others keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_rvalid <= 1'b0;
            vga_rdata  <= '0;
            a_ack      <= 1'b0;
            a_rdata    <= '0;
            b_ack      <= 1'b0;
            b_rdata    <= '0;
        end else begin
            vga_rvalid <= slot_owned_by(s2, PORT_VGA);
            a_ack      <= slot_owned_by(s2, PORT_A);
            b_ack      <= slot_owned_by(s2, PORT_B);
            if (slot_owned_by(s2, PORT_VGA)) begin
                vga_rdata <= ram_rdata;
            end
            if (slot_owned_by(s2, PORT_A)) begin
                a_rdata <= s2.we ? '0 : ram_rdata;
            end
            if (slot_owned_by(s2, PORT_B)) begin
                b_rdata <= s2.we ? '0 : ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_inflight <= 1'b0;
            b_inflight <= 1'b0;
        end else begin
            if (gnt[0]) begin
                a_inflight <= 1'b1;
            end else if (a_ack) begin
                a_inflight <= 1'b0;
            end
            if (gnt[1]) begin
                b_inflight <= 1'b1;
            end else if (b_ack) begin
                b_inflight <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model through an expected-completion queue.
module tb_vram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int EW = 2 + 32 + 8;   // {port, due cycle, data}

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_ack;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_ack      (a_ack),
        .a_rdata    (a_rdata),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_ack      (b_ack),
        .b_rdata    (b_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_s = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    // Write-first synchronous RAM seen by the DUT
    logic [DW-1:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] exp_last [0:2];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: completions and held rdata, sampled mid-cycle
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [2:0]    comp;
        logic [2:0]    exp_comp;
        int            p;
        comp = {b_ack, a_ack, vga_rvalid};
        if (rst_s) begin
            chk("reset_ctrl", {27'd0, ram_en, ram_we, comp}, 32'd0);
            chk("reset_addr", {21'd0, ram_addr}, 32'd0);
            chk("reset_wdata", {24'd0, ram_wdata}, 32'd0);
            chk("reset_rdata", {8'd0, vga_rdata, a_rdata, b_rdata}, 32'd0);
            for (int i = 0; i < 3; i++) exp_last[i] = '0;
        end else begin
            while (exp_q.size() > 0 && int'(exp_q[0][39:8]) < cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missed_completion @cyc %0d: got none expected port %0d due %0d",
                         cyc, e[41:40], e[39:8]);
            end
            if (exp_q.size() > 0 && int'(exp_q[0][39:8]) == cyc) begin
                e        = exp_q.pop_front();
                p        = int'(e[41:40]);
                exp_comp = 3'b000;
                exp_comp[p] = 1'b1;
                chk("completion_port", {29'd0, comp}, {29'd0, exp_comp});
                exp_last[p] = e[7:0];
            end else begin
                chk("no_spurious_completion", {29'd0, comp}, 32'd0);
            end
            chk("vga_rdata", {24'd0, vga_rdata}, {24'd0, exp_last[0]});
            chk("a_rdata", {24'd0, a_rdata}, {24'd0, exp_last[1]});
            chk("b_rdata", {24'd0, b_rdata}, {24'd0, exp_last[2]});
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:2047];
    int a_due = 0, b_due = 0, a_next = 0, b_next = 0;
    int last_game = 0;            // 0 none since reset, 1 A, 2 B
    bit a_busy = 0, b_busy = 0, a_done = 0, b_done = 0, vga_prev = 0;

    task automatic push(input logic [1:0] p, input logic [DW-1:0] d);
        exp_q.push_back({p, 32'(cyc + 3), d});
    endtask

    // Decide this cycle's winner from the current inputs
    task automatic step();
        bit ea, eb;
        int pick;
        if (rst) begin
            while (exp_q.size() > 0 && int'(exp_q[$][39:8]) > cyc) void'(exp_q.pop_back());
            a_busy = 0; b_busy = 0; a_next = 0; b_next = 0; last_game = 0;
            return;
        end
        if (vga_req) begin
            push(2'd0, ref_mem[vga_addr]);
            return;
        end
        ea = a_req && (cyc >= a_next);
        eb = b_req && (cyc >= b_next);
        if (ea && eb)  pick = (last_game == 1) ? 2 : 1;
        else if (ea)   pick = 1;
        else if (eb)   pick = 2;
        else           pick = 0;
        if (pick == 1) begin
            if (a_we) begin ref_mem[a_addr] = a_wdata; push(2'd1, 8'd0); end
            else push(2'd1, ref_mem[a_addr]);
            a_busy = 1; a_due = cyc + 3; a_next = cyc + 4; last_game = 1;
        end else if (pick == 2) begin
            if (b_we) begin ref_mem[b_addr] = b_wdata; push(2'd2, 8'd0); end
            else push(2'd2, ref_mem[b_addr]);
            b_busy = 1; b_due = cyc + 3; b_next = cyc + 4; last_game = 2;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        vga_prev = vga_req;
        @(posedge clk);
        #1;
        vga_req = 1'b0;
        a_done  = a_busy && (cyc == a_due);
        if (a_done) begin a_busy = 0; a_req = 1'b0; end
        b_done  = b_busy && (cyc == b_due);
        if (b_done) begin b_busy = 0; b_req = 1'b0; end
    endtask

    task automatic set_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
    endtask

    task automatic set_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin tick(); step(); end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (a_req || b_req); i++) begin tick(); step(); end
        n_vec++;
        if (a_req || b_req) begin
            n_bad++;
            $display("FAIL drain_timeout @cyc %0d: got req still pending expected idle", cyc);
        end
        idle(4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset held 5 cycles with A requesting, then A and B race on release
        rst = 1'b1;
        set_a(1'b0, 11'h005, 8'h00);
        repeat (5) begin tick(); step(); end
        tick();
        rst = 1'b0;
        set_b(1'b0, 11'h006, 8'h00);
        step();
        drain();

        // VGA-only scan of addresses 0..39 at the pixel-enable rate
        for (int i = 0; i < 40; i++) begin
            tick(); vga_req = 1'b1; vga_addr = 11'(i); step();
            tick(); step();
        end
        idle(4);

        // VGA and A collide in one cycle
        tick();
        vga_req = 1'b1; vga_addr = 11'd7;
        set_a(1'b1, 11'h100, 8'h2A);
        step();
        drain();

        // Both game ports held with VGA idle
        for (int i = 0; i < 24; i++) begin
            tick();
            if (!a_busy && !a_req) set_a(1'b0, 11'($urandom_range(0, 2047)), 8'h00);
            if (!b_busy && !b_req) set_b(1'b0, 11'($urandom_range(0, 2047)), 8'h00);
            step();
        end
        drain();

        // Write then read of the same address in consecutive slots
        tick(); set_a(1'b1, 11'h3FF, 8'h15); step();
        tick(); set_b(1'b0, 11'h3FF, 8'h00); step();
        for (int i = 0; i < 10 && !b_done; i++) begin tick(); step(); end
        if (b_done) begin
            @(negedge clk);
            #1;
            chk("raw_b_rdata", {24'd0, b_rdata}, 32'h15);
        end else begin
            chk("raw_b_ack_seen", 32'd0, 32'd1);
        end
        drain();

        // Reset one cycle after A's grant, then a clean restart
        tick(); set_a(1'b0, 11'h020, 8'h00); step();
        tick(); rst = 1'b1; a_req = 1'b0; step();
        tick(); step();
        tick(); rst = 1'b0; step();
        tick(); set_a(1'b0, 11'h020, 8'h00); step();
        drain();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (!vga_prev && $urandom_range(0, 1) == 1) begin
                vga_req  = 1'b1;
                vga_addr = 11'($urandom_range(0, 1199));
            end
            if (!a_busy) begin
                if (a_req) begin
                    if ($urandom_range(0, 4) == 0) a_req = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_a(1'($urandom_range(0, 1)), 11'($urandom_range(0, 63)), 8'($urandom));
                end
            end
            if (!b_busy) begin
                if (b_req) begin
                    if ($urandom_range(0, 4) == 0) b_req = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_b(1'($urandom_range(0, 1)), 11'($urandom_range(0, 63)), 8'($urandom));
                end
            end
            step();
        end
        a_req = a_busy;
        b_req = b_busy;
        drain();
        idle(4);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
